// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA channel arbiter.
// Optional feature macro used by the top: DMA_ARB_TIMEOUT_EN.
package dma_arb_pkg;

   localparam logic ARB_MODE_FIXED = 1'b0;
   localparam logic ARB_MODE_RR    = 1'b1;

   // Widest one-hot vector the index helper accepts
   localparam int OH_MAX = 32;

   typedef enum logic {
      ARB_IDLE,
      ARB_HOLD
   } arb_state_e;

   // One-hot to binary index; returns 0 for an all-zero vector
   function automatic logic [7:0] oh_to_idx(
      input logic [OH_MAX-1:0] oh
   );
      logic [7:0] idx;
      idx = '0;
      for (int i = 0; i < OH_MAX; i++) begin
         if (oh[i]) idx = idx | 8'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Rotating priority select: first set bit of vec_i at or after start_i,
// wrapping from N-1 back to 0. start_i = 0 gives plain LSB-first priority.
module dma_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  vec_i,
   input  logic [IW-1:0] start_i,
   output logic [N-1:0]  onehot_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   int j;

   // Scan N positions starting at start_i and keep the first hit
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      any_o    = 1'b0;
      j        = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(start_i) + k) % N;
         if (!any_o && vec_i[j]) begin
            any_o       = 1'b1;
            onehot_o[j] = 1'b1;
            idx_o       = IW'(j);
         end
      end
   end

endmodule

// File: rtl/dma_chan_arbiter.sv
// Burst-holding DMA channel arbiter, fixed or round-robin per mode input.
// Define DMA_ARB_TIMEOUT_EN to add a forced release after HOLD_MAX cycles.
module dma_chan_arbiter
   import dma_arb_pkg::*;
#(
   parameter int REQ_NUM  = 4,
   parameter int IDX_W    = $clog2(REQ_NUM),
   parameter int HOLD_MAX = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [REQ_NUM-1:0] reqs,
   input  logic [REQ_NUM-1:0] chan_en,
   input  logic               mode,
   input  logic               done,
   output logic [REQ_NUM-1:0] grants,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_id,
   output logic               timeout
);

   if (REQ_NUM < 2 || REQ_NUM > OH_MAX) begin : g_bad_req
      $error("REQ_NUM out of range");
   end
   if (HOLD_MAX < 2) begin : g_bad_hold
      $error("HOLD_MAX must be at least 2");
   end

   arb_state_e         state_q;
   logic [REQ_NUM-1:0] grants_q;
   logic [IDX_W-1:0]   rr_ptr_q;

   logic [REQ_NUM-1:0] elig;
   logic [REQ_NUM-1:0] arb_vec;
   logic [REQ_NUM-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   start;
   logic [IDX_W-1:0]   rr_ptr_d;
   logic               pick_any;
   logic               owner_req;
   logic               nat_rel;
   logic               tmo_hit;
   logic               rel;

   // Eligibility, release detection and arbitration input
   always_comb begin
      elig      = reqs & chan_en;
      owner_req = |(reqs & grants_q);
      nat_rel   = (state_q == ARB_HOLD) & (done | ~owner_req);
      rel       = nat_rel | tmo_hit;
      // The releasing owner is masked so it cannot win back-to-back
      arb_vec   = (state_q == ARB_HOLD) ? (elig & ~grants_q) : elig;
      start     = (mode == ARB_MODE_RR) ? rr_ptr_q : '0;
      if (pick_idx == IDX_W'(REQ_NUM - 1)) rr_ptr_d = '0;
      else                                  rr_ptr_d = pick_idx + 1'b1;
   end

   dma_rr_pick #(
      .N  (REQ_NUM),
      .IW (IDX_W)
   ) u_pick (
      .vec_i    (arb_vec),
      .start_i  (start),
      .onehot_o (pick_oh),
      .idx_o    (pick_idx),
      .any_o    (pick_any)
   );

`ifdef DMA_ARB_TIMEOUT_EN
   localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

   logic [CNT_W-1:0] hold_cnt_q;

   // Hold-cycle counter, cleared on every new grant or while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt_q <= '0;
      end else if (state_q == ARB_IDLE || rel) begin
         hold_cnt_q <= '0;
      end else begin
         hold_cnt_q <= hold_cnt_q + 1'b1;
      end
   end

   assign tmo_hit = (state_q == ARB_HOLD) &
                    (hold_cnt_q == CNT_W'(HOLD_MAX - 1));
   // Pulse only when the counter, not the owner, ends the burst
   assign timeout = tmo_hit & ~nat_rel;
`else
   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif

   // Arbitration FSM: grant from idle, hold, re-arbitrate on release
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         grants_q <= '0;
         rr_ptr_q <= '0;
      end else begin
         unique case (state_q)
            ARB_IDLE: begin
               if (pick_any) begin
                  grants_q <= pick_oh;
                  rr_ptr_q <= rr_ptr_d;
                  state_q  <= ARB_HOLD;
               end
            end
            ARB_HOLD: begin
               if (rel) begin
                  if (pick_any) begin
                     grants_q <= pick_oh;
                     rr_ptr_q <= rr_ptr_d;
                  end else begin
                     grants_q <= '0;
                     state_q  <= ARB_IDLE;
                  end
               end
            end
            default: begin
               grants_q <= '0;
               state_q  <= ARB_IDLE;
            end
         endcase
      end
   end

   assign grants      = grants_q;
   assign grant_valid = |grants_q;
   assign grant_id    = IDX_W'(oh_to_idx(OH_MAX'(grants_q)));

endmodule

// File: tb/tb_dma_chan_arbiter.sv
// Scoreboard bench for dma_chan_arbiter with REQ_NUM=4.
// Driver queues expected post-edge outputs; monitor pops and compares.
module tb_dma_chan_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] reqs;
   logic [3:0] chan_en;
   logic       mode;
   logic       done;
   logic [3:0] grants;
   logic       grant_valid;
   logic [1:0] grant_id;
   logic       timeout;

   typedef struct {
      logic [3:0] g;
      logic       t;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   dma_chan_arbiter #(
      .REQ_NUM  (4),
      .IDX_W    (2),
      .HOLD_MAX (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .reqs        (reqs),
      .chan_en     (chan_en),
      .mode        (mode),
      .done        (done),
      .grants      (grants),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .timeout     (timeout)
   );

   // Apply one cycle of inputs and queue the outputs expected after the edge
   task automatic cyc(
      input logic       r,
      input logic [3:0] rq,
      input logic [3:0] en,
      input logic       m,
      input logic       d,
      input logic [3:0] g,
      input string      tag,
      input logic       t = 1'b0
   );
      exp_t e;
      @(negedge clk);
      rst     = r;
      reqs    = rq;
      chan_en = en;
      mode    = m;
      done    = d;
      e.g     = g;
      e.t     = t;
      e.tag   = tag;
      q.push_back(e);
   endtask

   // Monitor: compare every sampled cycle that has an expectation queued
   initial begin
      exp_t       e;
      logic [1:0] eid;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e   = q.pop_front();
            eid = '0;
            for (int i = 0; i < 4; i++) if (e.g[i]) eid = 2'(i);
            n_vec++;
            if (grants !== e.g || grant_valid !== (|e.g) ||
                grant_id !== eid || timeout !== e.t) begin
               n_err++;
               $display("FAIL %s: got grants=%b id=%0d v=%b to=%b, need grants=%b id=%0d v=%b to=%b",
                        e.tag, grants, grant_id, grant_valid, timeout,
                        e.g, eid, |e.g, e.t);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; reqs = '0; chan_en = 4'hF; mode = 1'b0; done = 1'b0;

      // 1: fixed priority, hold until done
      cyc(1, 4'b0000, 4'hF, 0, 0, 4'b0000, "t1_rst0");
      cyc(1, 4'b0110, 4'hF, 0, 0, 4'b0000, "t1_rst1");
      cyc(0, 4'b0110, 4'hF, 0, 0, 4'b0010, "t1_grant");
      cyc(0, 4'b0110, 4'hF, 0, 0, 4'b0010, "t1_hold");
      cyc(0, 4'b0110, 4'hF, 0, 1, 4'b0100, "t1_done");
      cyc(0, 4'b0110, 4'hF, 0, 0, 4'b0100, "t1_hold2");
      cyc(0, 4'b0110, 4'hF, 0, 1, 4'b0010, "t1_back");
      cyc(0, 4'b0000, 4'hF, 0, 0, 4'b0000, "t1_drop");
      cyc(0, 4'b0000, 4'hF, 0, 1, 4'b0000, "t1_idle_done");

      // 2: round-robin, done every third cycle
      cyc(1, 4'b0000, 4'hF, 1, 0, 4'b0000, "t2_rst");
      cyc(0, 4'b1111, 4'hF, 1, 0, 4'b0001, "t2_g0");
      cyc(0, 4'b1111, 4'hF, 1, 0, 4'b0001, "t2_h0a");
      cyc(0, 4'b1111, 4'hF, 1, 0, 4'b0001, "t2_h0b");
      cyc(0, 4'b1111, 4'hF, 1, 1, 4'b0010, "t2_g1");
      cyc(0, 4'b1111, 4'hF, 1, 0, 4'b0010, "t2_h1a");
      cyc(0, 4'b1111, 4'hF, 1, 0, 4'b0010, "t2_h1b");
      cyc(0, 4'b1111, 4'hF, 1, 1, 4'b0100, "t2_g2");
      cyc(0, 4'b1111, 4'hF, 1, 0, 4'b0100, "t2_h2a");
      cyc(0, 4'b1111, 4'hF, 1, 0, 4'b0100, "t2_h2b");
      cyc(0, 4'b1111, 4'hF, 1, 1, 4'b1000, "t2_g3");
      cyc(0, 4'b1111, 4'hF, 1, 0, 4'b1000, "t2_h3a");
      cyc(0, 4'b1111, 4'hF, 1, 0, 4'b1000, "t2_h3b");
      cyc(0, 4'b1111, 4'hF, 1, 1, 4'b0001, "t2_wrap0");

      // 3: owner 2 drops request, zero-bubble handoff to 3
      cyc(0, 4'b1111, 4'hF, 1, 1, 4'b0010, "t3_g1");
      cyc(0, 4'b1111, 4'hF, 1, 1, 4'b0100, "t3_g2");
      cyc(0, 4'b1001, 4'hF, 1, 0, 4'b1000, "t3_drop");
      cyc(0, 4'b0000, 4'hF, 1, 0, 4'b0000, "t3_idle");

      // 4: channel enable mask
      cyc(0, 4'b0001, 4'b1110, 0, 0, 4'b0000, "t4_mask_a");
      cyc(0, 4'b0001, 4'b1110, 0, 0, 4'b0000, "t4_mask_b");
      cyc(0, 4'b0001, 4'b1111, 0, 0, 4'b0001, "t4_grant");
      cyc(0, 4'b0001, 4'b1110, 1, 0, 4'b0001, "t4_en_off");
      cyc(0, 4'b0001, 4'b1110, 0, 0, 4'b0001, "t4_held");
      cyc(0, 4'b0001, 4'b1110, 0, 1, 4'b0000, "t4_done");
      cyc(0, 4'b0001, 4'b1110, 0, 0, 4'b0000, "t4_stay");

      // 5: single requester idle gap, non-owner reqs, reset mid-hold
      cyc(0, 4'b0100, 4'hF, 0, 0, 4'b0100, "t5_grant");
      cyc(0, 4'b0100, 4'hF, 0, 1, 4'b0000, "t5_gap");
      cyc(0, 4'b0100, 4'hF, 0, 0, 4'b0100, "t5_regrant");
      cyc(0, 4'b0111, 4'hF, 0, 0, 4'b0100, "t5_no_preempt");
      cyc(0, 4'b0111, 4'hF, 0, 1, 4'b0001, "t5_next");
      cyc(1, 4'b0111, 4'hF, 0, 0, 4'b0000, "t5_rst");
      cyc(0, 4'b0100, 4'hF, 0, 0, 4'b0100, "t5_after_rst");
      cyc(0, 4'b0000, 4'hF, 0, 0, 4'b0000, "t5_idle");

`ifdef DMA_ARB_TIMEOUT_EN
      // 6: forced release on the 8th hold cycle
      cyc(1, 4'b0000, 4'hF, 0, 0, 4'b0000, "t6_rst");
      cyc(0, 4'b0011, 4'hF, 0, 0, 4'b0001, "t6_grant");
      for (int i = 0; i < 6; i++) begin
         cyc(0, 4'b0011, 4'hF, 0, 0, 4'b0001, "t6_hold");
      end
      cyc(0, 4'b0011, 4'hF, 0, 0, 4'b0001, "t6_pulse", 1'b1);
      cyc(0, 4'b0011, 4'hF, 0, 0, 4'b0010, "t6_moved");
      cyc(0, 4'b0000, 4'hF, 0, 0, 4'b0000, "t6_idle");
`endif

      @(negedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, need 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
